reg_write_arbiter: RTL and testbench
====================================

# reg_write_arbiter

Round-robin write arbiter and sequencer for a shared enable-gated data register. Up to N requesters compete for the register through a req/gnt/ack handshake. The block grants one requester at a time, captures that requester's write data, and drives a single-cycle write enable into the register it owns. It sits between the requesting engines and the shared storage element.

## Interface
Parameters:
- N, 4, number of requesters (N ≥ 2; need not be a power of two).
- WIDTH, 8, data width of the register and of each requester's write data.

Ports:
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- req  input  N  write request, one bit per requester. Level-sensitive.
- wdata  input  N*WIDTH  packed write data. Requester i uses wdata[i*WIDTH +: WIDTH].
- gnt  output  N  one-hot grant, registered. Asserted only in GRANT.
- ack  output  N  one-hot write acknowledge, registered. Asserted only in WRITE.
- en  output  1  register write enable, registered. Asserted only in WRITE.
- d  output  WIDTH  captured write data driven to the register.
- q  output  WIDTH  current contents of the shared register.
- busy  output  1  high whenever the state is not IDLE.

## Operation
- Internal state:
  - 2-bit FSM with states IDLE, GRANT, WRITE.
  - Pointer ptr of width max(1, clog2(N)), range 0..N-1.
  - Winner index w.
  - Data register d.
  - Storage register q.
- Round-robin selection: the winner is the first index i in the order ptr, ptr+1, …, N-1, 0, …, ptr-1 for which req[i]=1. Wrap is modulo N. Indices ≥ N are never produced.
- IDLE: gnt, ack and en are all 0.
  - If any req bit is 1, latch the winner into w, set gnt[w]=1 and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT (gnt[w]=1):
  - If req[w]=1: capture wdata slice w into d, clear gnt, set en=1 and ack[w]=1, and go to WRITE.
  - If req[w]=0 (abort): clear gnt and return to IDLE. No write occurs and ptr is unchanged.
- WRITE (en=1, ack[w]=1): at the closing edge:
  - q ← d.
  - en and ack clear.
  - ptr ← (w+1) mod N.
  - Go to IDLE.
- WRITE always returns to IDLE, so back-to-back writes are separated by one IDLE cycle.
- Requester protocol: the requester holds req and wdata stable until it sees ack, then drops req. A requester that still has req high in the following IDLE re-enters arbitration, but ptr has already moved past it.
- Requests that change while the block is in GRANT or WRITE have no effect, except the abort check on req[w] in GRANT.
- Reset (rst=1, at any time including mid-operation):
  - Immediately forces state=IDLE, ptr=0, w=0.
  - Forces gnt=0, ack=0, en=0, busy=0, d=0, q=0.
  - Any write in flight is dropped.
  - When rst deasserts, arbitration starts at the next edge.

## Timing
- Edge numbering: req is asserted before edge E1.
  - E1 → GRANT; gnt high.
  - E2 → WRITE; en and ack high, d valid.
  - E3 → q updated; IDLE.
- Latency from request to updated q is 3 edges.
- Sustained throughput is one write per 3 cycles.
- gnt is high for exactly 1 cycle. ack and en are high for exactly 1 cycle and are coincident.
- gnt, ack and en are never high together.
- busy is high during GRANT and WRITE, and low in IDLE.
- If every requester holds req continuously, grants rotate 0,1,…,N-1,0.

## Test plan
- Reset then idle, with rst pulsed asynchronously between edges:
  - All outputs 0 immediately.
  - req=0 for 10 cycles: busy stays 0 and q stays 0.
- Single request, WIDTH=8, N=4: req=4'b0100 with slice 2=8'hA5.
  - gnt=0100 after E1.
  - en=1, ack=0100 and d=A5 after E2.
  - q=A5 after E3.
- Fairness: req=4'b1111 held with distinct data per slice.
  - Grant order is 0,1,2,3,0.
  - Every write is separated by one IDLE cycle.
  - q follows each winner's data.
- Wrap and skip: after requester 3 wins, ptr=0. With req=4'b1010, requester 1 wins next, then requester 3.
- Abort: req[1] drops during GRANT.
  - No en and no ack.
  - q is unchanged.
  - The next arbitration still starts from the old ptr.
- Reset mid-write: assert rst during WRITE with d=8'h3C.
  - q=0, en=0, ack=0 at once.
  - The old data never appears on q.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
//
// Round-robin write arbiter and sequencer for one shared, enable-gated data
// register. Several requesters compete through a req/gnt/ack handshake. The
// block grants one requester at a time, captures that requester's write data
// into d, and pulses en for one cycle. At the closing edge of that cycle the
// shared register q loads d.
//
// Sequence for one write (3 edges):
//   IDLE  --(any req)-->  GRANT  --(req[w] held)-->  WRITE  -->  IDLE
//                           |
//                           +--(req[w] dropped: abort)-->  IDLE
//
// Parameters
//   N      number of requesters (N >= 2, need not be a power of two)
//   WIDTH  data width of the register and of each requester's write data
//
// Ports
//   clk    in   1        rising-edge clock
//   rst    in   1        asynchronous, active-high reset
//   req    in   N        level-sensitive write request, one bit per requester
//   wdata  in   N*WIDTH  packed write data; requester i uses slice i
//   gnt    out  N        one-hot grant, registered, high only in GRANT
//   ack    out  N        one-hot write acknowledge, registered, high only in WRITE
//   en     out  1        register write enable, registered, high only in WRITE
//   d      out  WIDTH    captured write data presented to the register
//   q      out  WIDTH    current contents of the shared register
//   busy   out  1        high whenever the sequencer is not in IDLE
// -----------------------------------------------------------------------------
module reg_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       req,
  input  logic [N*WIDTH-1:0] wdata,
  output logic [N-1:0]       gnt,
  output logic [N-1:0]       ack,
  output logic               en,
  output logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  output logic               busy
);

  // Index width for ptr and w; at least one bit.
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;     // first index to examine in the next arbitration
  logic [PW-1:0]   w;       // requester owning the current transaction

  // Arbitration result for the current cycle.
  logic            any_req;
  logic [PW-1:0]   win;

  // Request bit and data slice of the current owner w.
  logic            w_req;
  logic [WIDTH-1:0] w_data;

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Position k in the search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  // Both operands are below N, so one conditional subtraction is an exact
  // modulo and no index >= N is ever produced.
  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  // One-hot vector with bit idx set.
  function automatic logic [N-1:0] one_hot(input logic [PW-1:0] idx);
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == PW'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

  // Successor of an index, wrapping at N rather than at 2**PW.
  function automatic logic [PW-1:0] next_index(input logic [PW-1:0] idx);
    if (idx == PW'(N - 1)) return '0;
    return idx + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Round-robin selection: first requesting index starting from ptr.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the loop so that no path
    // leaves it unassigned; otherwise a latch is inferred.
    any_req = 1'b0;
    win     = '0;
    for (int k = 0; k < N; k++) begin
      if (!any_req && req[rr_index(ptr, k)]) begin
        any_req = 1'b1;
        win     = rr_index(ptr, k);
      end
    end
  end

  // Request bit and data slice of the current owner. Written as a decoded
  // mux so the slice index never leaves the valid range.
  always_comb begin
    w_req  = 1'b0;
    w_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w == PW'(i)) begin
        w_req  = req[i];
        w_data = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer with registered handshake outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: q is the storage element itself, not a memory array, and it
      // must read 0 straight after reset, so it sits on the reset branch
      // together with the control state.
      state <= IDLE;
      ptr   <= '0;
      w     <= '0;
      gnt   <= '0;
      ack   <= '0;
      en    <= 1'b0;
      d     <= '0;
      q     <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // sees the values from before this edge (e.g. q <= d takes the old d).
      case (state)
        IDLE: begin
          gnt <= '0;
          ack <= '0;
          en  <= 1'b0;
          if (any_req) begin
            w     <= win;
            gnt   <= one_hot(win);
            state <= GRANT;
          end
        end

        GRANT: begin
          gnt <= '0;
          if (w_req) begin
            d     <= w_data;
            en    <= 1'b1;
            ack   <= one_hot(w);
            state <= WRITE;
          end else begin
            // Abort: owner withdrew before the write; ptr stays put so the
            // next arbitration starts from the same place.
            state <= IDLE;
          end
        end

        WRITE: begin
          q     <= d;
          en    <= 1'b0;
          ack   <= '0;
          ptr   <= next_index(w);
          state <= IDLE;
        end

        default: begin
          // Unused encoding: recover quietly to IDLE with outputs idle.
          gnt   <= '0;
          ack   <= '0;
          en    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Handshake invariants
  // ---------------------------------------------------------------------------
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(ack));
  a_en_with_ack: assert property (@(posedge clk) disable iff (rst) en == (|ack));
  a_gnt_excl:   assert property (@(posedge clk) disable iff (rst) !((|gnt) && en));
  a_ptr_range:  assert property (@(posedge clk) disable iff (rst) int'(ptr) < N);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
//
// Self-checking bench for reg_write_arbiter (N=4, WIDTH=8). Each expected
// write (winner index, data) is queued when the request is driven; a monitor
// pops an entry whenever en is seen and tracks the expected contents of q.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [N-1:0]       req = '0;
  logic [N*WIDTH-1:0] wdata = '0;
  logic [N-1:0]       gnt;
  logic [N-1:0]       ack;
  logic               en;
  logic [WIDTH-1:0]   d;
  logic [WIDTH-1:0]   q;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int               idx;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t              sb[$];
  wr_t              mon_e;
  logic [WIDTH-1:0] exp_q     = '0;
  logic [WIDTH-1:0] pend_data = '0;
  bit               q_pending = 1'b0;

  reg_write_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .en    (en),
    .d     (d),
    .q     (q),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_data(input int i, input logic [WIDTH-1:0] val);
    wdata[i*WIDTH +: WIDTH] = val;
  endtask

  task automatic push_exp(input int i, input logic [WIDTH-1:0] val);
    wr_t e;
    e.idx  = i;
    e.data = val;
    sb.push_back(e);
  endtask

  // Monitor: compares every write against the scoreboard and q against the
  // modelled register contents, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (q_pending) begin
        exp_q     = pend_data;
        q_pending = 1'b0;
      end
      check("q", 32'(q), 32'(exp_q));
      check("gnt_en_excl", 32'((|gnt) & en), 0);
      if (en) begin
        if (sb.size() == 0) begin
          check("unexpected_write", 32'(en), 0);
        end else begin
          mon_e = sb.pop_front();
          check("wr_ack", 32'(ack), 32'(oh(mon_e.idx)));
          check("wr_d", 32'(d), 32'(mon_e.data));
          q_pending = 1'b1;
          pend_data = mon_e.data;
        end
      end
    end
  end

  // A reset drops any write in flight and clears the register.
  always @(posedge rst) begin
    q_pending = 1'b0;
    exp_q     = '0;
  end

  task automatic wait_grant();
    int t;
    t = 0;
    while (gnt == '0 && t < 10) begin
      @(negedge clk);
      t++;
    end
  endtask

  // Follow one complete transaction for requester idx, from grant to the
  // IDLE cycle after the write. drop=1 releases req[idx] on seeing ack.
  task automatic expect_write(input int idx, input bit drop);
    wait_grant();
    check("gnt", 32'(gnt), 32'(oh(idx)));
    check("gnt_no_en", 32'(en), 0);
    check("busy_grant", 32'(busy), 1);
    @(negedge clk);
    check("en", 32'(en), 1);
    check("ack", 32'(ack), 32'(oh(idx)));
    check("gnt_clear", 32'(gnt), 0);
    if (drop) req[idx] = 1'b0;
    @(negedge clk);
    check("idle_busy", 32'(busy), 0);
    check("idle_en", 32'(en), 0);
    check("idle_ack", 32'(ack), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},  32'(gnt),  0);
    check({tag, "_ack"},  32'(ack),  0);
    check({tag, "_en"},   32'(en),   0);
    check({tag, "_d"},    32'(d),    0);
    check({tag, "_q"},    32'(q),    0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    // Reset and idle, including an asynchronous pulse between edges.
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    check_all_zero("rst_init");
    @(negedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("rst_async");
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_busy10", 32'(busy), 0);
      check("idle_q10", 32'(q), 0);
    end

    // Single request: requester 2 writes A5.
    set_data(2, 8'hA5);
    req = 4'b0100;
    push_exp(2, 8'hA5);
    expect_write(2, 1'b1);
    check("single_q", 32'(q), 32'h0A5);

    // Wrap: ptr is 3, so requester 3 wins and ptr wraps to 0.
    set_data(3, 8'h5A);
    req = 4'b1000;
    push_exp(3, 8'h5A);
    expect_write(3, 1'b1);

    // Skip: with ptr 0 and req 1010, requester 1 then requester 3.
    set_data(1, 8'h11);
    set_data(3, 8'h33);
    req = 4'b1010;
    push_exp(1, 8'h11);
    push_exp(3, 8'h33);
    expect_write(1, 1'b1);
    expect_write(3, 1'b1);

    // Fairness: all requests held continuously, grants rotate 0,1,2,3,0.
    set_data(0, 8'h10);
    set_data(1, 8'h21);
    set_data(2, 8'h42);
    set_data(3, 8'h84);
    req = 4'b1111;
    push_exp(0, 8'h10);
    push_exp(1, 8'h21);
    push_exp(2, 8'h42);
    push_exp(3, 8'h84);
    push_exp(0, 8'h10);
    for (int i = 0; i < 5; i++) expect_write(i % N, 1'b0);
    req = '0;

    // Abort: ptr is 1; requester 1 is granted and then withdraws.
    req = 4'b0010;
    @(negedge clk);
    check("abort_gnt", 32'(gnt), 32'(oh(1)));
    req = '0;
    @(negedge clk);
    check("abort_en", 32'(en), 0);
    check("abort_ack", 32'(ack), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_q", 32'(q), 32'h010);
    @(negedge clk);
    check("abort_no_en", 32'(en), 0);

    // ptr still 1: with req 0011, requester 1 wins before requester 0.
    set_data(0, 8'hC0);
    set_data(1, 8'hC1);
    req = 4'b0011;
    push_exp(1, 8'hC1);
    push_exp(0, 8'hC0);
    expect_write(1, 1'b1);
    expect_write(0, 1'b1);

    // Reset mid-write: 3C must never reach q.
    set_data(2, 8'h3C);
    req = 4'b0100;
    push_exp(2, 8'h3C);
    wait_grant();
    check("rmw_gnt", 32'(gnt), 32'(oh(2)));
    @(negedge clk);
    check("rmw_en", 32'(en), 1);
    check("rmw_d", 32'(d), 32'h03C);
    #2 rst = 1'b1;
    req = '0;
    #1 check_all_zero("rmw_rst");
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("rmw_q_after", 32'(q), 0);
      check("rmw_busy_after", 32'(busy), 0);
    end

    // ptr back to 0 after reset: req 0110 gives requester 1, then 2.
    set_data(1, 8'h66);
    set_data(2, 8'h99);
    req = 4'b0110;
    push_exp(1, 8'h66);
    push_exp(2, 8'h99);
    expect_write(1, 1'b1);
    expect_write(2, 1'b1);
    repeat (2) @(negedge clk);

    check("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit reached");
  end

endmodule
